branch_resolution_unit: RTL and testbench

- Execute-side producer of branch target buffer updates; the write end of the interface fetch reads from.
- Fetch enqueues one prediction record per predicted branch (PC, predicted taken, predicted target) into an in-order queue.
- Execute resolves branches oldest-first. The block compares each actual outcome against its queued prediction, emits the BTB update (write, taken, new_pc, data), and on a mispredict issues a redirect and flushes wrong-path records.
- Keeps saturating branch and mispredict counters.

---
 rtl/branch_resolution_unit.sv | 95 +++++++++
 tb/tb_branch_resolution_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: in-order prediction queue, BTB update producer and mispredict redirect
module branch_resolution_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             bru_clk,
  input  logic             bru_reset,
  input  logic             bru_push,
  input  logic [PC_W-1:0]  bru_push_pc,
  input  logic             bru_push_pred_taken,
  input  logic [PC_W-1:0]  bru_push_pred_target,
  output logic             bru_full,
  output logic             bru_empty,
  input  logic             bru_resolve,
  input  logic             bru_actual_taken,
  input  logic [PC_W-1:0]  bru_actual_target,
  output logic             bru_btb_write,
  output logic             bru_btb_branch_taken,
  output logic [PC_W-1:0]  bru_btb_new_pc,
  output logic [PC_W-1:0]  bru_btb_data,
  output logic             bru_redirect,
  output logic [PC_W-1:0]  bru_redirect_pc,
  output logic             bru_underflow,
  output logic [CNT_W-1:0] bru_branch_count,
  output logic [CNT_W-1:0] bru_mispredict_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0] state;
  logic [PC_W-1:0] q_pc [DEPTH];
  logic [PC_W-1:0] q_tgt [DEPTH];
  logic [DEPTH-1:0] q_taken;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic pop, mis, push_ok, head_taken;
  logic [PC_W-1:0] head_pc, head_tgt;
  assign bru_full = count == CW'(DEPTH) || state == FLUSH;
  assign bru_empty = count == '0;
  always_comb begin
    head_pc = q_pc[rd_ptr];
    head_tgt = q_tgt[rd_ptr];
    head_taken = q_taken[rd_ptr];
    pop = state == RUN && bru_resolve && count != '0;
    mis = pop && (head_taken != bru_actual_taken || (bru_actual_taken && head_tgt != bru_actual_target));
    push_ok = bru_push && !bru_full && !mis;
  end
  always_ff @(posedge bru_clk) begin
    if (push_ok) begin
      q_pc[wr_ptr] <= bru_push_pc;
      q_tgt[wr_ptr] <= bru_push_pred_target;
      q_taken[wr_ptr] <= bru_push_pred_taken;
    end
  end
  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      bru_btb_write <= 1'b0;
      bru_btb_branch_taken <= 1'b0;
      bru_btb_new_pc <= '0;
      bru_btb_data <= '0;
      bru_redirect <= 1'b0;
      bru_redirect_pc <= '0;
      bru_underflow <= 1'b0;
      bru_branch_count <= '0;
      bru_mispredict_count <= '0;
    end else begin
      state <= mis ? FLUSH : RUN;
      bru_btb_write <= pop;
      bru_redirect <= mis;
      if (state == RUN && bru_resolve && count == '0) bru_underflow <= 1'b1;
      if (pop) begin
        bru_btb_branch_taken <= bru_actual_taken;
        bru_btb_new_pc <= head_pc;
        bru_btb_data <= bru_actual_taken ? bru_actual_target : head_tgt;
        bru_branch_count <= bru_branch_count + CNT_W'(bru_branch_count != '1);
      end
      if (mis) begin
        bru_redirect_pc <= bru_actual_taken ? bru_actual_target : head_pc + PC_W'(4);
        bru_mispredict_count <= bru_mispredict_count + CNT_W'(bru_mispredict_count != '1);
        rd_ptr <= wr_ptr;
        count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_ok) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: randomized bench checked against a queue-based reference model
module tb_branch_resolution_unit;
  localparam int DEPTH = 4;
  localparam int CMAX = 15;
  typedef struct {
    logic [31:0] pc;
    logic pt;
    logic [31:0] tgt;
  } rec_t;
  logic clk = 0, rst = 1, push = 0, ppt = 0, res = 0, at = 0;
  logic [31:0] ppc = 0, ptg = 0, atg = 0;
  logic full, empty, bw, btaken, redir, uf;
  logic [31:0] newpc, bdata, rpc;
  logic [3:0] bc, mc;
  int checks = 0, failures = 0;
  rec_t mq[$];
  bit m_flush, m_uf, e_write, e_taken, e_redir;
  int m_bc, m_mc;
  logic [31:0] e_newpc, e_data, e_rpc, pc_next;
  always #5 clk = ~clk;
  branch_resolution_unit #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(4)) dut (
    .bru_clk(clk), .bru_reset(rst), .bru_push(push), .bru_push_pc(ppc),
    .bru_push_pred_taken(ppt), .bru_push_pred_target(ptg), .bru_full(full), .bru_empty(empty),
    .bru_resolve(res), .bru_actual_taken(at), .bru_actual_target(atg), .bru_btb_write(bw),
    .bru_btb_branch_taken(btaken), .bru_btb_new_pc(newpc), .bru_btb_data(bdata),
    .bru_redirect(redir), .bru_redirect_pc(rpc), .bru_underflow(uf),
    .bru_branch_count(bc), .bru_mispredict_count(mc)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic model();
    bit was_full, pop, mis;
    rec_t h;
    if (rst) begin
      mq.delete();
      {m_flush, m_uf, e_write, e_taken, e_redir} = '0;
      m_bc = 0;
      m_mc = 0;
      e_newpc = 0;
      e_data = 0;
      e_rpc = 0;
      return;
    end
    was_full = mq.size() == DEPTH || m_flush;
    pop = !m_flush && res && mq.size() > 0;
    mis = 0;
    if (!m_flush && res && mq.size() == 0) m_uf = 1;
    e_write = pop;
    e_redir = 0;
    if (pop) begin
      h = mq[0];
      mis = h.pt != at || (at && h.tgt != atg);
      e_taken = at;
      e_newpc = h.pc;
      e_data = at ? atg : h.tgt;
      m_bc = m_bc < CMAX ? m_bc + 1 : CMAX;
      if (mis) begin
        e_redir = 1;
        e_rpc = at ? atg : h.pc + 4;
        m_mc = m_mc < CMAX ? m_mc + 1 : CMAX;
      end
    end
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push && !was_full) mq.push_back('{ppc, ppt, ptg});
    end
    m_flush = mis;
  endtask
  task automatic compare();
    chk("btb_write", bw, e_write);
    chk("btb_taken", btaken, e_taken);
    chk("btb_new_pc", newpc, e_newpc);
    chk("btb_data", bdata, e_data);
    chk("redirect", redir, e_redir);
    if (e_redir) chk("redirect_pc", rpc, e_rpc);
    chk("underflow", uf, m_uf);
    chk("branch_count", bc, m_bc);
    chk("mispredict_count", mc, m_mc);
    chk("full", full, mq.size() == DEPTH || m_flush);
    chk("empty", empty, mq.size() == 0);
  endtask
  task automatic cycle(input logic r, input logic ps, input logic [31:0] pp, input logic pt,
                       input logic [31:0] pg, input logic rs, input logic a, input logic [31:0] ag);
    @(negedge clk);
    {rst, push, ppc, ppt, ptg, res, at, atg} = {r, ps, pp, pt, pg, rs, a, ag};
    model();
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic resolve_ok();
    cycle(0, 0, 0, 0, 0, 1, mq[0].pt, mq[0].tgt);
  endtask
  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_empty", empty, 1);
    chk("reset_count", bc, 0);
    cycle(0, 1, 32'h4, 1, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    chk("t1_write", bw, 1);
    chk("t1_new_pc", newpc, 32'h4);
    chk("t1_data", bdata, 32'hDEADBEEF);
    chk("t1_redirect", redir, 0);
    chk("t1_branch_count", bc, 1);
    chk("t1_empty", empty, 1);
    cycle(0, 1, 32'h1000, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'hDEADFEED);
    chk("t2_redirect", redir, 1);
    chk("t2_redirect_pc", rpc, 32'hDEADFEED);
    chk("t2_data", bdata, 32'hDEADFEED);
    chk("t2_mispredict_count", mc, 1);
    chk("t2_flush_full", full, 1);
    idle();
    chk("t2_run_full", full, 0);
    cycle(0, 1, 32'h1004, 1, 32'hFEEDBEEF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t3_redirect_pc", rpc, 32'h1008);
    chk("t3_taken", btaken, 0);
    chk("t3_data", bdata, 32'hFEEDBEEF);
    idle();
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'(i * 4), 0, 32'h3000, 0, 0, 0);
    chk("t4_full", full, 1);
    cycle(0, 1, 32'h10, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h5000);
    chk("t4_new_pc", newpc, 32'h0);
    chk("t4_empty", empty, 1);
    cycle(0, 1, 32'h20, 0, 0, 0, 0, 0);
    chk("t4_flush_push_empty", empty, 1);
    idle();
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h100 + 32'(i * 4), 1, 32'h2000 + 32'(i), 0, 0, 0);
    pc_next = 32'h110;
    for (int i = 0; i < 6; i++) begin
      bit acc;
      acc = mq.size() < DEPTH && !m_flush;
      cycle(0, 1, pc_next, 1, pc_next + 32'h1000, 1, mq[0].pt, mq[0].tgt);
      if (acc) pc_next += 4;
      chk("t5_new_pc", newpc, 32'h100 + 32'(i * 4));
    end
    while (mq.size() > 0) resolve_ok();
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    chk("t6_underflow", uf, 1);
    chk("t6_no_write", bw, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h80);
    cycle(1, 1, 32'h44, 0, 0, 1, 0, 0);
    chk("t6_rst_underflow", uf, 0);
    chk("t6_rst_data", bdata, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_mc", mc, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, a;
      logic [31:0] g;
      r = $urandom_range(0, 199) == 0;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        a = mq[0].pt;
        g = mq[0].tgt;
      end else begin
        a = 1'($urandom_range(0, 1));
        g = 32'h4000 + 32'($urandom_range(0, 3) * 4);
      end
      cycle(r, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
            32'h4000 + 32'($urandom_range(0, 3) * 4), $urandom_range(0, 2) != 0, a, g);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
